// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider timebase.
// Holds the board clock frequency, common divisor presets and a helper
// that converts a desired tick frequency into a divisor value.
package clk_div_pkg;

  // 12 MHz board oscillator
  localparam int unsigned CLK_HZ = 12000000;

  // 20 Hz tick / 10 Hz square output
  localparam int unsigned DIV_10HZ_SQ = 600000;
  // 1 kHz tick / 500 Hz square output
  localparam int unsigned DIV_1KHZ = 12000;

  // Divisor giving a tick rate of f Hz. A zero request maps to a stopped
  // channel (divisor 0) instead of dividing by zero.
  function automatic int unsigned hz_to_div(input int unsigned f);
    if (f == 0) begin
      return 0;
    end
    return CLK_HZ / f;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: divisor register, counter, tick strobe and
// 50%-duty square output, including the per-channel priority
// (reset > write > sync > count).
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   en        count enable
//   sync      restart counter and square output
//   wr        write strobe already decoded for this channel
//   wr_div    divisor value to load on wr
//   tick      registered one-cycle strobe every div cycles
//   sq        registered square output, period 2*div
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          DIV_W   = 20,
  parameter int unsigned DEF_DIV = DIV_10HZ_SQ
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             sq
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    sq_d   = sq_q;
    tick_d = 1'b0;
    if (wr) begin
      // A write also restarts the channel so cnt can never sit above a
      // newly written, smaller divisor.
      div_d = wr_div;
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (sync) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (div_q == '0) begin
      // Divisor zero parks the channel with everything low.
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en) begin
      if (cnt_q == div_q - DIV_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q  <= DIV_W'(DEF_DIV);
      cnt_q  <= '0;
      sq_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable tick / square-wave generator used as the
// system timebase. Holds the divisor write decode and the write
// acknowledge/error pulses; each channel is a clk_div_chan instance.
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   en        global count enable
//   sync      restart all channels in phase
//   wr_en     divisor write strobe
//   wr_ch     channel index for the write
//   wr_div    divisor value
//   wr_ack    one-cycle pulse after an accepted write
//   wr_err    one-cycle pulse after a write to a nonexistent channel
//   tick      per-channel one-cycle strobe
//   sq        per-channel square output
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          DIV_W   = 20,
  parameter int unsigned DEF_DIV = DIV_10HZ_SQ,
  parameter int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic              wr_valid;
  logic [NUM_CH-1:0] wr_sel;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;

  // One extra bit so the range check stays meaningful when NUM_CH is not
  // a power of two (wr_ch can then name channels that do not exist).
  assign wr_valid = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));

  always_comb begin
    wr_ack_d = wr_valid;
    wr_err_d = wr_en && !wr_valid;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_ack = wr_ack_q;
  assign wr_err = wr_err_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign wr_sel[gi] = wr_valid && (wr_ch == CH_W'(gi));

      clk_div_chan #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .CLK    (CLK),
        .RST    (RST),
        .en     (en),
        .sync   (sync),
        .wr     (wr_sel[gi]),
        .wr_div (wr_div),
        .tick   (tick[gi]),
        .sq     (sq[gi])
      );
    end
  endgenerate

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider/tick generator running from the 12 MHz board clock.
- Each channel produces a one-cycle strobe (tick) and a 50%-duty square output (sq).
- Divisors are run-time writable through a one-cycle write port.
- A global sync input phase-aligns all channels.
- Serves as the system update/sample timebase for the joystick controller and its peripherals (SPI pacing, LED refresh, display update).

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_W, 20, divisor/counter width in bits.
- DEF_DIV, 600000, reset divisor for every channel. Gives a 20 Hz tick and 10 Hz sq at 12 MHz.
- CH_W, $clog2(NUM_CH) (minimum 1), channel-index width.

Ports:
- CLK  in  1  system clock, 12 MHz.
- RST  in  1  reset, synchronous, active-high.
- en  in  1  global count enable.
- sync  in  1  phase-align pulse; restarts all channels.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  CH_W  target channel for the write.
- wr_div  in  DIV_W  new divisor value.
- wr_ack  out  1  one-cycle pulse: write accepted.
- wr_err  out  1  one-cycle pulse: write rejected (wr_ch >= NUM_CH).
- tick  out  NUM_CH  per-channel one-cycle strobe.
- sq  out  NUM_CH  per-channel square output.

Behaviour:
- Clock and reset: all logic on posedge CLK. Reset is synchronous and active-high on RST.
- Reset values:
  - tick = 0, sq = 0, wr_ack = 0, wr_err = 0.
  - Every cnt = 0, every div = DEF_DIV.
- Per-channel state: div[DIV_W], cnt[DIV_W], sq bit. All outputs are registered; there are no combinational paths from inputs to outputs.
- Counting (en=1, div=D>=1, no write/sync to this channel):
  - When cnt != D-1: cnt increments and tick=0.
  - When cnt == D-1: cnt <= 0, tick <= 1 for exactly one cycle, sq <= ~sq.
  - Tick period is D cycles. sq period is 2*D cycles at 50% duty.
  - After reset release with en=1, the first tick is asserted on the D-th rising edge.
  - D=1: tick is high continuously and sq toggles every cycle.
- Divisor zero (div=0): channel stopped. cnt is held at 0, tick=0, sq is forced to 0.
- en=0: all cnt and sq hold their values, tick=0. Writes and sync are still honoured.
- Write handshake:
  - On a cycle with wr_en=1 and wr_ch<NUM_CH:
    - div[wr_ch] <= wr_div, cnt[wr_ch] <= 0, sq[wr_ch] <= 0.
    - wr_ack=1 on the next cycle.
  - On a cycle with wr_en=1 and wr_ch>=NUM_CH: no state change; wr_err=1 on the next cycle.
  - Back-to-back writes are accepted every cycle; the ack/err pulses follow each write by one cycle.
- sync: on a cycle with sync=1, every channel gets cnt <= 0, sq <= 0, tick <= 0. div is unchanged.
- Priority per channel, highest first: RST > write to this channel > sync > count.
  - A write or sync coinciding with a terminal count suppresses that tick and that toggle.
  - A simultaneous write and sync both restart the channel, and the written divisor takes effect.
- Wrap-around: cnt never exceeds div-1. A write of a smaller div is safe because the write also clears cnt.
- Reset mid-operation: all state returns to reset values on the next edge. Any pending wr_ack/wr_err is dropped.

Decomposition:
- Shared package clk_div_pkg holds:
  - DEF_DIV presets, e.g. DIV_10HZ_SQ=600000 and DIV_1KHZ=12000.
  - The CLK_HZ=12000000 constant.
  - A function hz_to_div(f) = CLK_HZ/f.
- Sub-module clk_div_chan: one channel's counter, div register, sq and tick, plus the priority logic. The top instantiates NUM_CH copies of it and holds the write decode and ack/err registers.

Test Plan:
1. Reset then en=1, defaults with DEF_DIV overridden to 5 for simulation -> tick[0] high at cycles 5, 10, 15; sq[0] toggles 0->1 at cycle 5 and 1->0 at cycle 10.
2. Write ch1 div=3 mid-count -> wr_ack one cycle later. ch1 cnt and sq restart; ticks come every 3 cycles starting 3 cycles after the write. Other channels are unaffected.
3. Write ch=NUM_CH (invalid) div=7 -> wr_err pulse only, no wr_ack, every div unchanged.
4. Set div=0 on ch2 -> tick[2]=0 and sq[2]=0 indefinitely. Writing div=1 then gives tick[2] constantly high and sq[2] toggling every cycle.
5. Hold en=0 for 10 cycles mid-period with div=4 -> no ticks and sq frozen. After en returns to 1, the remaining count resumes, so the first tick arrives after the remaining cycles rather than after a full 4.
6. Assert sync on a ch0 terminal-count cycle, and separately RST during active writes -> the tick is suppressed and all channels realign with identical phase. RST returns outputs to 0 and div to DEF_DIV, with no wr_ack emitted.
